// File: rtl/mem_arbiter_pkg.sv
// Shared types and limits for the fetch/data memory arbiter.
// Counter width is sized to hold the largest supported read latency.
package mem_arbiter_pkg;

    localparam int unsigned LAT_MAX = 4;
    localparam int unsigned CNT_W   = $clog2(LAT_MAX + 1);

    typedef enum logic [1:0] {
        IDLE,
        READ_WAIT,
        WRITE
    } state_e;

    typedef enum logic {
        FETCH,
        DATA
    } grant_e;

endpackage

// File: rtl/mem_arbiter_lat.sv
// Read-latency down-counter: loaded with the latency on a read grant, decremented while waiting.
// zero flags the cycle whose decrement reaches zero, i.e. the read completion cycle.
module lat_counter
    import mem_arbiter_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             dec,
    input  logic [CNT_W-1:0] load_val,
    output logic             zero
);

    logic [CNT_W-1:0] count_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            count_q <= '0;
        end else if (load) begin
            count_q <= load_val;
        end else if (dec && (count_q != '0)) begin
            count_q <= count_q - CNT_W'(1);
        end
    end

    assign zero = dec && (count_q == CNT_W'(1));

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter between instruction fetch and data ports onto one single-port memory.
// Grants are taken in IDLE and in the completion cycle of an access for back-to-back service.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned LAT = 1,
    parameter int unsigned AW  = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic [31:0]   if_rdata,
    output logic          if_valid,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [31:0]   d_wdata,
    output logic [31:0]   d_rdata,
    output logic          d_valid,
    output logic [AW-1:0] mem_addr,
    output logic [31:0]   mem_wdata,
    output logic          mem_we,
    input  logic [31:0]   mem_rdata,
    output logic          stall
);

    state_e state_q;
    grant_e last_grant_q;
    grant_e winner;
    logic   cnt_load, cnt_dec, cnt_zero;
    logic   completing, arb_point, if_elig, d_elig, grant;

    lat_counter u_lat_counter (
        .clk      (clk),
        .rst      (rst),
        .load     (cnt_load),
        .dec      (cnt_dec),
        .load_val (CNT_W'(LAT)),
        .zero     (cnt_zero)
    );

    // A requester that is completing, or whose valid is showing, still holds a stale req.
    always_comb begin
        cnt_dec    = (state_q == READ_WAIT);
        completing = cnt_zero || (state_q == WRITE);
        arb_point  = (state_q == IDLE) || completing;
        if_elig    = if_req && !if_valid && !(completing && (last_grant_q == FETCH));
        d_elig     = d_req && !d_valid && !(completing && (last_grant_q == DATA));
        grant      = arb_point && (if_elig || d_elig);
        if (if_elig && d_elig) begin
            winner = (last_grant_q == FETCH) ? DATA : FETCH;
        end else begin
            winner = if_elig ? FETCH : DATA;
        end
        cnt_load = grant && ((winner == FETCH) || !d_we);
    end

    assign stall = (if_req && !if_valid) || (d_req && !d_valid);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= IDLE;
            last_grant_q <= FETCH;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            mem_we       <= 1'b0;
            if_rdata     <= '0;
            d_rdata      <= '0;
            if_valid     <= 1'b0;
            d_valid      <= 1'b0;
        end else begin
            if_valid <= 1'b0;
            d_valid  <= 1'b0;
            mem_we   <= 1'b0;
            if (cnt_zero) begin
                if (last_grant_q == FETCH) begin
                    if_rdata <= mem_rdata;
                    if_valid <= 1'b1;
                end else begin
                    d_rdata <= mem_rdata;
                    d_valid <= 1'b1;
                end
            end
            if (state_q == WRITE) begin
                d_valid <= 1'b1;
            end
            if (grant) begin
                last_grant_q <= winner;
                mem_addr     <= (winner == FETCH) ? if_addr : d_addr;
                if ((winner == DATA) && d_we) begin
                    state_q   <= WRITE;
                    mem_we    <= 1'b1;
                    mem_wdata <= d_wdata;
                end else begin
                    state_q <= READ_WAIT;
                end
            end else if (completing) begin
                state_q <= IDLE;
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a LAT=1 and a LAT=3 instance share stimulus,
// each backed by a combinational memory model.
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    localparam int unsigned AW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          if_req, d_req, d_we;
    logic [AW-1:0] if_addr, d_addr;
    logic [31:0]   d_wdata;

    logic [31:0]   if_rdata1, d_rdata1, mem_wdata1, mem_rdata1;
    logic [AW-1:0] mem_addr1;
    logic          if_valid1, d_valid1, mem_we1, stall1;
    logic [31:0]   if_rdata3, d_rdata3, mem_wdata3, mem_rdata3;
    logic [AW-1:0] mem_addr3;
    logic          if_valid3, d_valid3, mem_we3, stall3;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_model(input logic [AW-1:0] a);
        if (a == 32'h10) return 32'hE3A0_1005;
        return a ^ 32'hA5A5_0000;
    endfunction

    assign mem_rdata1 = mem_model(mem_addr1);
    assign mem_rdata3 = mem_model(mem_addr3);

    mem_arbiter #(.LAT(1), .AW(AW)) u1 (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata1), .if_valid(if_valid1),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata1), .d_valid(d_valid1),
        .mem_addr(mem_addr1), .mem_wdata(mem_wdata1), .mem_we(mem_we1),
        .mem_rdata(mem_rdata1), .stall(stall1)
    );

    mem_arbiter #(.LAT(3), .AW(AW)) u3 (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata3), .if_valid(if_valid3),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata3), .d_valid(d_valid3),
        .mem_addr(mem_addr3), .mem_wdata(mem_wdata3), .mem_we(mem_we3),
        .mem_rdata(mem_rdata3), .stall(stall3)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst    = 1'b0;
        if_req = 1'b0;
        d_req  = 1'b0;
        d_we   = 1'b0;
        tick();
        tick();
        rst = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        rst = 1'b0; if_req = 1'b1; if_addr = 32'h10;
        d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;

        // Reset held two cycles with a fetch pending
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("rst_if_valid1", if_valid1, 0);
            chk("rst_d_valid1", d_valid1, 0);
            chk("rst_mem_we1", mem_we1, 0);
            chk("rst_mem_addr1", mem_addr1, 0);
            chk("rst_mem_wdata1", mem_wdata1, 0);
            chk("rst_if_rdata1", if_rdata1, 0);
            chk("rst_d_rdata1", d_rdata1, 0);
            chk("rst_if_valid3", if_valid3, 0);
            chk("rst_mem_we3", mem_we3, 0);
        end

        // Lone fetch, LAT=1
        rst = 1'b1;
        chk("fetch_stall_c0", stall1, 1);
        tick();
        chk("fetch_addr_c1", mem_addr1, 32'h10);
        chk("fetch_valid_c1", if_valid1, 0);
        chk("fetch_stall_c1", stall1, 1);
        tick();
        chk("fetch_valid_c2", if_valid1, 1);
        chk("fetch_rdata_c2", if_rdata1, 32'hE3A0_1005);
        chk("fetch_stall_c2", stall1, 0);
        chk("fetch_dvalid_c2", d_valid1, 0);
        if_req = 1'b0;
        tick();
        chk("fetch_valid_c3", if_valid1, 0);
        chk("fetch_rdata_hold", if_rdata1, 32'hE3A0_1005);

        // Tie after reset: data first, fetch back-to-back
        do_reset();
        if_req = 1'b1; if_addr = 32'h20; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h30;
        tick();
        chk("tie_first_addr", mem_addr1, 32'h30);
        tick();
        chk("tie_d_valid", d_valid1, 1);
        chk("tie_d_rdata", d_rdata1, mem_model(32'h30));
        chk("tie_second_addr", mem_addr1, 32'h20);
        chk("tie_if_valid_early", if_valid1, 0);
        chk("tie_stall_fetch", stall1, 1);
        d_req = 1'b0;
        tick();
        chk("tie_if_valid", if_valid1, 1);
        chk("tie_d_valid_off", d_valid1, 0);
        chk("tie_if_rdata", if_rdata1, mem_model(32'h20));
        if_req = 1'b0;
        tick();
        chk("tie_if_valid_off", if_valid1, 0);

        // Store
        do_reset();
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h40; d_wdata = 32'hDEAD_BEEF;
        tick();
        chk("st_mem_we", mem_we1, 1);
        chk("st_mem_addr", mem_addr1, 32'h40);
        chk("st_mem_wdata", mem_wdata1, 32'hDEAD_BEEF);
        chk("st_d_valid_early", d_valid1, 0);
        chk("st_mem_we3", mem_we3, 1);
        tick();
        chk("st_mem_we_off", mem_we1, 0);
        chk("st_d_valid", d_valid1, 1);
        chk("st_stall", stall1, 0);
        chk("st_d_rdata_kept", d_rdata1, 0);
        d_req = 1'b0; d_we = 1'b0;
        tick();
        chk("st_d_valid_off", d_valid1, 0);

        // Reset during the WRITE cycle
        do_reset();
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h44; d_wdata = 32'h1234_5678;
        tick();
        chk("wabort_mem_we", mem_we1, 1);
        rst = 1'b0;
        tick();
        chk("wabort_mem_we_off", mem_we1, 0);
        chk("wabort_no_valid", d_valid1, 0);
        rst = 1'b1; d_req = 1'b0; d_we = 1'b0;
        tick();
        chk("wabort_no_valid_late", d_valid1, 0);

        // LAT=3 read, reset when the counter is at 1
        do_reset();
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h50;
        tick();
        tick();
        tick();
        chk("rabort_addr", mem_addr3, 32'h50);
        chk("rabort_valid_pre", d_valid3, 0);
        rst = 1'b0;
        tick();
        chk("rabort_no_valid", d_valid3, 0);
        chk("rabort_state_idle", 32'(u3.state_q), 32'(IDLE));
        chk("rabort_addr_clr", mem_addr3, 0);
        chk("rabort_rdata_clr", d_rdata3, 0);
        rst = 1'b1; d_req = 1'b0;
        tick();
        chk("rabort_no_valid_late", d_valid3, 0);

        // Continuous fetch and data reads: eight alternating grants on the LAT=3 instance
        do_reset();
        if_req = 1'b1; if_addr = 32'h100; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h200;
        for (int k = 1; k <= 24; k++) begin
            tick();
            chk($sformatf("alt_addr_c%0d", k), mem_addr3,
                (((k - 1) / 3) % 2 == 0) ? 32'h200 : 32'h100);
            chk($sformatf("alt_dvalid_c%0d", k), d_valid3,
                (k >= 4 && (k - 4) % 6 == 0) ? 1 : 0);
            chk($sformatf("alt_ivalid_c%0d", k), if_valid3,
                (k >= 7 && (k - 7) % 6 == 0) ? 1 : 0);
            chk($sformatf("alt_excl1_c%0d", k), if_valid1 & d_valid1, 0);
            if (k == 4) chk("alt_d_rdata", d_rdata3, mem_model(32'h200));
            if (k == 7) chk("alt_if_rdata", if_rdata3, mem_model(32'h100));
        end
        if_req = 1'b0; d_req = 1'b0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
